// File: rtl/dm_byte_resp_if.sv
// Request/response bundle for the byte-addressable data memory.
// Handshake: req_valid qualifies op/addr/byte_en/wdata in the cycle it is high;
// there is no ready, so the memory takes every valid request. rdata_valid
// qualifies rdata for exactly one cycle, and addr_err is a one-cycle pulse.
interface dm_byte_resp_if;
    logic        req_valid;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        addr_err;
    logic [7:0]  err_cnt;

    modport master (
        output req_valid, op, addr, byte_en, wdata,
        input  rdata, rdata_valid, addr_err, err_cnt
    );

    modport slave (
        input  req_valid, op, addr, byte_en, wdata,
        output rdata, rdata_valid, addr_err, err_cnt
    );
endinterface

// File: rtl/dm_byte_resp.sv
// Word-organised data memory serving MIPS byte/half/word loads and stores.
// Stores commit at the request edge; loads return one cycle later, extended.
// Illegal requests (misaligned, out of range, wrong lane enables) are dropped
// and reported through addr_err and a saturating err_cnt.
module dm_byte_resp #(
    parameter int DEPTH_WORDS = 4096
) (
    input logic           clk,
    input logic           reset,
    dm_byte_resp_if.slave bus
);
    localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH_WORDS);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    logic [31:0] mem [DEPTH_WORDS];

    logic             is_load;
    logic             is_store;
    logic             is_half;
    logic             is_word;
    logic [3:0]       exp_be;
    logic             misalign;
    logic             out_of_range;
    logic             be_bad;
    logic             active;
    logic             reject;
    logic             do_load;
    logic             do_store;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      wr_word;

    logic        ld_valid;
    logic [31:0] ld_word;
    logic [1:0]  ld_off;
    logic [5:0]  ld_op;
    logic        err_q;
    logic [7:0]  err_cnt_q;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] ext_data;

    // Decode the opcode into access class/size and the lane mask a legal store must carry.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_half  = 1'b0;
        is_word  = 1'b0;
        case (bus.op)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin is_load = 1'b1; is_half = 1'b1; end
            OP_LW:         begin is_load = 1'b1; is_word = 1'b1; end
            OP_SB:         is_store = 1'b1;
            OP_SH:         begin is_store = 1'b1; is_half = 1'b1; end
            OP_SW:         begin is_store = 1'b1; is_word = 1'b1; end
            default:       ;
        endcase
        if (is_word)
            exp_be = 4'b1111;
        else if (is_half)
            exp_be = bus.addr[1] ? 4'b1100 : 4'b0011;
        else
            exp_be = 4'b0001 << bus.addr[1:0];
    end

    assign misalign     = (is_half & bus.addr[0]) | (is_word & (|bus.addr[1:0]));
    assign out_of_range = {2'b00, bus.addr[31:2]} >= DEPTH_LIM;
    assign be_bad       = is_store & (bus.byte_en != exp_be);
    assign active       = bus.req_valid & (is_load | is_store);
    assign reject       = active & (misalign | out_of_range | be_bad);
    assign do_load      = active & is_load & ~reject;
    assign do_store     = active & is_store & ~reject;
    assign word_idx     = bus.addr[IDX_W+1:2];

    // Byte stores go to every lane and halves to both halves; byte_en picks the live ones.
    assign wr_word = is_word ? bus.wdata :
                     is_half ? {2{bus.wdata[15:0]}} : {4{bus.wdata[7:0]}};

    // Memory array: cleared wholesale on reset, lane-masked write on an accepted store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++)
                mem[i] <= '0;
        end else if (do_store) begin
            for (int l = 0; l < 4; l++)
                if (bus.byte_en[l])
                    mem[word_idx][8*l +: 8] <= wr_word[8*l +: 8];
        end
    end

    // Load response stage and error reporting, one cycle behind the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_valid  <= 1'b0;
            ld_word   <= '0;
            ld_off    <= '0;
            ld_op     <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            ld_valid <= do_load;
            err_q    <= reject;
            if (do_load) begin
                ld_word <= mem[word_idx];
                ld_off  <= bus.addr[1:0];
                ld_op   <= bus.op;
            end
            if (reject && err_cnt_q != 8'hFF)
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    // Pick the addressed lane/half of the captured word and extend it by load type.
    always_comb begin
        case (ld_off)
            2'd0:    lane_byte = ld_word[7:0];
            2'd1:    lane_byte = ld_word[15:8];
            2'd2:    lane_byte = ld_word[23:16];
            default: lane_byte = ld_word[31:24];
        endcase
        lane_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_op)
            OP_LB:   ext_data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  ext_data = {24'd0, lane_byte};
            OP_LH:   ext_data = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  ext_data = {16'd0, lane_half};
            default: ext_data = ld_word;
        endcase
    end

    // A reset arriving in the response cycle cancels the pending load and error pulse.
    assign bus.rdata_valid = ld_valid & ~reset;
    assign bus.rdata       = bus.rdata_valid ? ext_data : 32'd0;
    assign bus.addr_err    = err_q & ~reset;
    assign bus.err_cnt     = err_cnt_q;
endmodule
